// File: rtl/nand_sweep_pkg.sv
// nand_sweep_pkg: shared state encoding and vector-order constants for the NAND sweep checker
package nand_sweep_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;
    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;
endpackage

// File: rtl/nand_sweep_checker_vec_map.sv
// vec_map: maps the sweep index to the driven vector in binary or Gray order
module vec_map import nand_sweep_pkg::*; #(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] idx,
    input  logic            mode,
    output logic [N_IN-1:0] vec
);
    always_comb vec = (mode == MODE_GRAY) ? idx ^ (idx >> 1) : idx;
endmodule

// File: rtl/nand_sweep_checker.sv
// nand_sweep_checker: exhaustively sweeps a NAND under test and counts output mismatches
module nand_sweep_checker import nand_sweep_pkg::*; #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic            i_abort,
    input  logic            i_dut_f,
    output logic [N_IN-1:0] o_vec,
    output logic            o_busy,
    output logic            o_done,
    output logic [N_IN:0]   o_err_cnt,
    output logic            o_err_seen,
    output logic [N_IN-1:0] o_first_err
);
    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN-1:0] IDX_ONE  = 1;
    localparam logic [N_IN:0]   ERR_ONE  = 1;
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
    state_t          state, state_nx;
    logic [N_IN-1:0] idx, mapped;
    logic [3:0]      cnt;
    logic            mode, mismatch;
    vec_map #(.N_IN(N_IN)) u_map (.idx(idx), .mode(mode), .vec(mapped));
    assign mismatch   = i_dut_f != ~&o_vec;
    assign o_busy     = state != S_IDLE;
    assign o_done     = state == S_DONE;
    assign o_err_seen = |o_err_cnt;
    always_ff @(posedge i_clk) state <= i_rst ? S_IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = i_start ? S_DRIVE : S_IDLE;
            S_DRIVE:  state_nx = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: state_nx = (cnt == CNT_LAST) ? S_CHECK : S_SETTLE;
            S_CHECK:  state_nx = (idx == IDX_LAST) ? S_DONE : S_DRIVE;
            default:  state_nx = S_IDLE;
        endcase
        if (i_abort && state != S_IDLE) state_nx = S_IDLE;
    end
    // abort discards the in-flight check so partial results reflect completed vectors only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx         <= '0;
            mode        <= MODE_BIN;
            cnt         <= '0;
            o_vec       <= '0;
            o_err_cnt   <= '0;
            o_first_err <= '0;
        end else if (i_abort && o_busy) begin
            o_vec <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    mode        <= i_mode;
                    idx         <= '0;
                    o_err_cnt   <= '0;
                    o_first_err <= '0;
                end
                S_DRIVE: begin
                    o_vec <= mapped;
                    cnt   <= '0;
                end
                S_SETTLE: cnt <= cnt + 4'd1;
                S_CHECK: begin
                    if (mismatch) begin
                        o_err_cnt <= o_err_cnt + ERR_ONE;
                        if (o_err_cnt == '0) o_first_err <= o_vec;
                    end
                    if (idx != IDX_LAST) idx <= idx + IDX_ONE;
                end
                default: ;
            endcase
        end
    end
endmodule
